// File: rtl/fifo1.sv
// fifo1: single-clock first-word-fall-through FIFO, 2**ASIZE x DSIZE register storage.
// Latency: a written word appears on rdata the cycle after the write edge; rdata itself is combinational from the head slot.
// Backpressure: wfull rejects writes and rempty rejects reads; both flags are registered and exact, with no lag cycle.
//
// Ports:
//   wclk    in   single clock; every register updates on its rising edge
//   wrst    in   synchronous active-high reset; overrides winc/rinc
//   wdata   in   DSIZE write word
//   winc    in   write request, accepted when wfull=0
//   rinc    in   read/pop request, accepted when rempty=0
//   rdata   out  head-of-queue word (stale slot contents while rempty=1)
//   wfull   out  FIFO holds 2**ASIZE words
//   rempty  out  FIFO holds 0 words
//   count   out  occupancy 0..2**ASIZE (only when FIFO1_COUNT_EN is defined)
//
// Optional feature macro: FIFO1_COUNT_EN adds the registered count output.

module fifo1 #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
`ifdef FIFO1_COUNT_EN
  ,
  output logic [ASIZE:0]   count
`endif
);

  localparam int DEPTH = 2 ** ASIZE;

  // Storage is deliberately left out of reset; only the pointers define validity.
  logic [DSIZE-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic           wfull_q, wfull_d;
  logic           rempty_q, rempty_d;
  logic           wr_acc;
  logic           rd_acc;

  always_comb begin
    wr_acc   = winc & ~wfull_q;
    rd_acc   = rinc & ~rempty_q;
    wptr_d   = wptr_q + (ASIZE+1)'(wr_acc);
    rptr_d   = rptr_q + (ASIZE+1)'(rd_acc);
    // Flags are computed from the post-edge pointers so they never lag occupancy.
    rempty_d = (wptr_d == rptr_d);
    wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
               (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
    end
  end

  // A write under reset is dropped too, so nothing lands in a slot the reset just freed.
  always_ff @(posedge wclk) begin
    if (!wrst && wr_acc) begin
      mem_q[wptr_q[ASIZE-1:0]] <= wdata;
    end
  end

  assign rdata  = mem_q[rptr_q[ASIZE-1:0]];
  assign wfull  = wfull_q;
  assign rempty = rempty_q;

`ifdef FIFO1_COUNT_EN
  logic [ASIZE:0] count_q, count_d;

  always_comb begin
    // Modulo subtraction of the wrap-bit pointers gives 0..DEPTH directly.
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_fifo1.sv
// tb_fifo1: directed and randomized stimulus for fifo1 against a queue-based reference model.
// Latency: outputs are sampled 1 time unit after each rising edge and compared with the model state after that edge.
// Backpressure: the model accepts a write only below 16 words and a read only above 0 words, reading before writing.

module tb_fifo1;

  localparam int DEPTH = 16;

  logic       wclk;
  logic       wrst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
`ifdef FIFO1_COUNT_EN
  logic [4:0] count;
`endif

  int tests_run;
  int tests_failed;

  logic [7:0] mq[$];

  fifo1 #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
`ifdef FIFO1_COUNT_EN
    ,
    .count  (count)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the queue rules, then compare.
  task automatic step(input logic rst, input logic w, input logic [7:0] d, input logic r);
    int occ;
    bit wacc;
    bit racc;
    wrst  = rst;
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge wclk);
    occ  = mq.size();
    if (rst) begin
      mq.delete();
    end else begin
      racc = r && (occ > 0);
      wacc = w && (occ < DEPTH);
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
    end
    #1;
    check("rempty", 32'(rempty), 32'(mq.size() == 0));
    check("wfull",  32'(wfull),  32'(mq.size() == DEPTH));
    if (mq.size() > 0) check("rdata", 32'(rdata), 32'(mq[0]));
`ifdef FIFO1_COUNT_EN
    check("count", 32'(count), 32'(mq.size()));
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wrst  = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;

    // Reset three cycles (with requests active to show reset wins), then idle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hEE, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_rempty", 32'(rempty), 32'd1);
    check("reset_wfull",  32'(wfull),  32'd0);

    // Fill with 0..15, then an ignored 0xAA write while full.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    check("full_after_16", 32'(wfull), 32'd1);

    // Drain 16 words in order; the model checks rdata each cycle.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(rdata), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);  // read while empty is ignored
    check("empty_after_drain", 32'(rempty), 32'd1);

    // Wrap test: 10 in / 10 out, then 0x20..0x2F across the pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("wrap_order", 32'(rdata), 32'(8'h20 + i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end

    // Simultaneous read+write at empty (-> 1 word).
    step(1'b0, 1'b1, 8'h61, 1'b1);
    check("sim_empty_rdata", 32'(rdata), 32'h61);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    // Mid (8 words): occupancy unchanged.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b0, 1'b1, 8'h78, 1'b1);
    check("sim_mid_head", 32'(rdata), 32'h71);
    // Full: read accepted, write rejected (-> 15 words).
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 1'b1, 8'hBB, 1'b1);
    check("sim_full_wfull", 32'(wfull), 32'd0);
    while (mq.size() > 0) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset with 5 queued words, then a single 0x55 write.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_mid_rempty", 32'(rempty), 32'd1);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    check("rst_then_55", 32'(rdata), 32'h55);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized phases with varying write/read bias and rare resets.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      int rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 20;
      rp = 100 - wp;
      for (int i = 0; i < 500; i++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < wp),
             8'($urandom),
             ($urandom_range(0, 99) < rp));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
